// File: rtl/uart_msg_streamer.sv
// Programmable message buffer streamed out over a UART line with clock-enable baud ticks.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits (8E1 framing).
module uart_msg_streamer #(
  parameter int CLK_DIV   = 1250,
  parameter int MSG_DEPTH = 16,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 0,
  parameter int NULL_TERM = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         start,
  input  logic                         repeat_en,
  input  logic                         stop_req,
  output logic                         tx,
  output logic                         busy,
  output logic                         byte_done,
  output logic                         msg_done,
  output logic [$clog2(MSG_DEPTH)-1:0] char_idx
);

  localparam int            AW      = $clog2(MSG_DEPTH);
  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(MSG_DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, PARITY, STOP, GAP, FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW:0]   len_q;
  logic          rep_q;
  logic          stop_pend;
  logic          null_hit;

  logic [7:0]    mem [MSG_DEPTH];
  logic [7:0]    cur_byte;
  logic          tick;
  logic          last_idx;
  logic          stop_now;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    cur_byte = mem[char_idx];
    tick     = (cnt == CNT_MAX);
    last_idx = (({1'b0, char_idx} + (AW + 1)'(1)) == len_q);
    stop_now = stop_pend | stop_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      len_q     <= '0;
      rep_q     <= 1'b0;
      stop_pend <= 1'b0;
      null_hit  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      msg_done  <= 1'b0;
      char_idx  <= '0;
    end else begin
      byte_done <= 1'b0;
      msg_done  <= 1'b0;

      // The baud counter only runs during bit states so LOAD/FIN cost one cycle each
      // and every bit lasts exactly CLK_DIV cycles.
      if (state inside {START, DATA, PARITY, STOP, GAP})
        cnt <= tick ? '0 : cnt + 1'b1;
      else
        cnt <= '0;

      if (state != IDLE && stop_req) stop_pend <= 1'b1;

      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          tx        <= 1'b1;
          if (start && msg_len != '0) begin
            len_q    <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
            rep_q    <= repeat_en;
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          shreg   <= cur_byte;
          bit_cnt <= '0;
          if (NULL_TERM != 0 && cur_byte == 8'h00) begin
            null_hit <= 1'b1;
            state    <= FIN;
          end else begin
            null_hit <= 1'b0;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (tick) begin
            tx      <= shreg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              tx    <= ^shreg;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[bit_cnt[2:0] + 3'd1];
            end
          end
        end

        PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            if (int'(bit_cnt) >= STOP_BITS - 1) begin
              byte_done <= 1'b1;
              bit_cnt   <= '0;
              state     <= (GAP_BITS == 0) ? FIN : GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        GAP: begin
          if (tick) begin
            if (int'(bit_cnt) >= GAP_BITS - 1) state <= FIN;
            else                               bit_cnt <= bit_cnt + 1'b1;
          end
        end

        FIN: begin
          if (null_hit || last_idx) begin
            msg_done <= 1'b1;
            if (rep_q && !stop_now) begin
              char_idx <= '0;
              state    <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (stop_now) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            char_idx <= char_idx + 1'b1;
            state    <= LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
